// File: rtl/adc_trig_pkg.sv
// rtl/adc_trig_pkg.sv - shared encodings for the ADC trigger sequencer
//
// Purpose: state, mode and slope encodings used by the sequencer top level
// and its level detector. No ports.

package adc_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_FIRE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_STOP   = 2'd3
  } trig_mode_e;

  typedef enum logic {
    SLOPE_RISING  = 1'b0,
    SLOPE_FALLING = 1'b1
  } trig_slope_e;

endpackage

// File: rtl/trig_level_detect.sv
// rtl/trig_level_detect.sv - hysteresis thresholds and prime/edge compares
//
// Purpose: derives the saturated lo/hi hysteresis thresholds around
// trig_level and flags the prime and edge conditions for the current sample.
// Purely combinational; both flags are forced low when sample_en=0.
// Ports:
//   adc_data   in  ADC_W  current filtered sample
//   sample_en  in  1      sample strobe
//   trig_level in  ADC_W  threshold, unsigned
//   trig_hyst  in  8      hysteresis in LSBs
//   trig_slope in  1      0=rising, 1=falling
//   prime_hit  out 1      sample is on the far side of the hysteresis band
//   edge_hit   out 1      sample has crossed trig_level in the slope direction

module trig_level_detect
  import adc_trig_pkg::*;
#(
  parameter int ADC_W = 12
) (
  input  logic [ADC_W-1:0] adc_data,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] trig_level,
  input  logic [7:0]       trig_hyst,
  input  logic             trig_slope,
  output logic             prime_hit,
  output logic             edge_hit
);

  logic [ADC_W:0]   level_x;
  logic [ADC_W:0]   hyst_x;
  logic [ADC_W:0]   diff_x;
  logic [ADC_W:0]   sum_x;
  logic [ADC_W-1:0] lo;
  logic [ADC_W-1:0] hi;

  always_comb begin
    level_x = {1'b0, trig_level};
    hyst_x  = (ADC_W+1)'(trig_hyst);
    diff_x  = level_x - hyst_x;
    sum_x   = level_x + hyst_x;

    // One extra bit catches the borrow / carry so the band clamps at the
    // ends of the ADC range instead of wrapping around.
    lo = diff_x[ADC_W] ? '0 : diff_x[ADC_W-1:0];
    hi = sum_x[ADC_W]  ? '1 : sum_x[ADC_W-1:0];

    prime_hit = 1'b0;
    edge_hit  = 1'b0;
    if (sample_en) begin
      if (trig_slope == SLOPE_FALLING) begin
        prime_hit = (adc_data >= hi);
        edge_hit  = (adc_data <= trig_level);
      end else begin
        prime_hit = (adc_data <= lo);
        edge_hit  = (adc_data >= trig_level);
      end
    end
  end

endmodule

// File: rtl/adc_trigger_sequencer.sv
// rtl/adc_trigger_sequencer.sv - DSO trigger arming / firing sequencer
//
// Purpose: arms on the hysteresis prime condition, fires on the level edge
// (or on the auto timeout), handshakes with the capture controller and
// applies a post-capture holdoff before re-arming. Runs auto / normal /
// single / stop scope modes.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   adc_data       filtered sample, valid with sample_en
//   sample_en      sample strobe (capture controller mem_en)
//   cap_triggered  capture controller is filling the post-trigger buffer
//   cap_done       capture controller is swapping banks
//   trig_level, trig_hyst, trig_slope   trigger threshold setup
//   trig_mode      0=auto 1=normal 2=single 3=stop
//   arm_single     one-clk pulse arming single mode from IDLE
//   holdoff        sample ticks to wait after cap_done
//   auto_timeout   clk cycles before a forced trigger in auto, 0=never
//   trigger_req    registered trigger request (high throughout FIRE)
//   trig_forced    last firing came from the auto timeout
//   single_done    sticky, single capture finished
//   trig_count     triggers issued, wraps
//   seq_state      state register readback

module adc_trigger_sequencer
  import adc_trig_pkg::*;
#(
  parameter int ADC_W  = 12,
  parameter int HOLD_W = 20,
  parameter int TO_W   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              sample_en,
  input  logic              cap_triggered,
  input  logic              cap_done,
  input  logic [ADC_W-1:0]  trig_level,
  input  logic [7:0]        trig_hyst,
  input  logic              trig_slope,
  input  logic [1:0]        trig_mode,
  input  logic              arm_single,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [TO_W-1:0]   auto_timeout,
  output logic              trigger_req,
  output logic              trig_forced,
  output logic              single_done,
  output logic [15:0]       trig_count,
  output logic [2:0]        seq_state
);

  seq_state_e        state_q, state_d;
  logic              trigger_req_q, trigger_req_d;
  logic              trig_forced_q, trig_forced_d;
  logic              single_done_q, single_done_d;
  logic [15:0]       trig_count_q, trig_count_d;
  logic [TO_W-1:0]   to_ctr_q, to_ctr_d;
  logic [HOLD_W-1:0] hold_ctr_q, hold_ctr_d;
  // 0 while HOLDOFF still waits for cap_done, 1 once counting sample ticks
  logic              cap_seen_q, cap_seen_d;

  logic              prime_hit;
  logic              edge_hit;
  logic              run_free;
  logic              timeout_hit;
  logic              hold_expired;
  logic              hold_done;
  logic [TO_W-1:0]   to_ctr_inc;

  trig_level_detect #(
    .ADC_W (ADC_W)
  ) u_level_detect (
    .adc_data   (adc_data),
    .sample_en  (sample_en),
    .trig_level (trig_level),
    .trig_hyst  (trig_hyst),
    .trig_slope (trig_slope),
    .prime_hit  (prime_hit),
    .edge_hit   (edge_hit)
  );

  always_comb begin
    run_free    = (trig_mode == MODE_AUTO) || (trig_mode == MODE_NORMAL);
    // >= rather than == so lowering auto_timeout below the running count
    // fires at once instead of waiting for the saturated counter.
    timeout_hit = (trig_mode == MODE_AUTO) && (auto_timeout != '0) &&
                  (to_ctr_q >= auto_timeout - TO_W'(1));
    to_ctr_inc  = (to_ctr_q == '1) ? to_ctr_q : to_ctr_q + TO_W'(1);
    // The tick being counted now is included; holdoff=0 is covered too.
    hold_expired = ({1'b0, hold_ctr_q} + (HOLD_W+1)'(1)) >= {1'b0, holdoff};
  end

  always_comb begin
    state_d       = state_q;
    trig_forced_d = trig_forced_q;
    single_done_d = single_done_q;
    trig_count_d  = trig_count_q;
    to_ctr_d      = to_ctr_q;
    hold_ctr_d    = hold_ctr_q;
    cap_seen_d    = cap_seen_q;
    hold_done     = 1'b0;

    // Stop overrides everything and leaves the sticky status untouched.
    if (trig_mode == MODE_STOP) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run_free || ((trig_mode == MODE_SINGLE) && arm_single)) begin
            state_d  = ST_PRIME;
            to_ctr_d = '0;
            if ((trig_mode == MODE_SINGLE) && arm_single) begin
              single_done_d = 1'b0;
            end
          end
        end

        ST_PRIME: begin
          to_ctr_d = to_ctr_inc;
          if (timeout_hit) begin
            state_d       = ST_FIRE;
            trig_forced_d = 1'b1;
          end else if (prime_hit) begin
            state_d = ST_ARMED;
          end
        end

        ST_ARMED: begin
          to_ctr_d = to_ctr_inc;
          // A real edge takes priority over a timeout on the same cycle.
          if (edge_hit) begin
            state_d       = ST_FIRE;
            trig_forced_d = 1'b0;
          end else if (timeout_hit) begin
            state_d       = ST_FIRE;
            trig_forced_d = 1'b1;
          end
        end

        ST_FIRE: begin
          if (cap_triggered) begin
            state_d      = ST_HOLDOFF;
            trig_count_d = trig_count_q + 16'd1;
            cap_seen_d   = 1'b0;
            hold_ctr_d   = '0;
          end
        end

        ST_HOLDOFF: begin
          if (!cap_seen_q) begin
            if (cap_done) begin
              if (holdoff == '0) begin
                hold_done = 1'b1;
              end else begin
                cap_seen_d = 1'b1;
                hold_ctr_d = '0;
              end
            end
          end else if (sample_en) begin
            if (hold_expired) begin
              hold_done = 1'b1;
            end else begin
              hold_ctr_d = hold_ctr_q + HOLD_W'(1);
            end
          end

          // Mode is sampled at exit, so a switch to single mid-cycle
          // finishes this capture and then parks in IDLE.
          if (hold_done) begin
            if (trig_mode == MODE_SINGLE) begin
              state_d       = ST_IDLE;
              single_done_d = 1'b1;
            end else begin
              state_d  = ST_PRIME;
              to_ctr_d = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    trigger_req_d = (state_d == ST_FIRE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      trigger_req_q <= 1'b0;
      trig_forced_q <= 1'b0;
      single_done_q <= 1'b0;
      trig_count_q  <= '0;
      to_ctr_q      <= '0;
      hold_ctr_q    <= '0;
      cap_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      trigger_req_q <= trigger_req_d;
      trig_forced_q <= trig_forced_d;
      single_done_q <= single_done_d;
      trig_count_q  <= trig_count_d;
      to_ctr_q      <= to_ctr_d;
      hold_ctr_q    <= hold_ctr_d;
      cap_seen_q    <= cap_seen_d;
    end
  end

  assign trigger_req = trigger_req_q;
  assign trig_forced = trig_forced_q;
  assign single_done = single_done_q;
  assign trig_count  = trig_count_q;
  assign seq_state   = state_q;

endmodule
